sm3_stream_core: RTL

SM3_STREAM_CORE -- requirements
Module: sm3_stream_core

---
 rtl/sm3_pkg.sv | 38 +++
 rtl/sm3_round.sv | 32 +++
 rtl/sm3_stream_core.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sm3_pkg.sv
// sm3_pkg: constants, state encoding and boolean helpers shared by the SM3
// streaming core and its round datapath.
//   SM3_IV       initial chaining value V0..V7 (V0 in bits 255:224)
//   T_LO / T_HI  round constants for rounds 0-15 / 16-63
//   state_t      controller states
//   rotl, p0, p1, ff, gg  SM3 primitive functions
package sm3_pkg;

   localparam logic [255:0] SM3_IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
   localparam logic [31:0]  T_LO   = 32'h79cc4519;
   localparam logic [31:0]  T_HI   = 32'h7a879d8a;

   typedef enum logic [2:0] {IDLE, LOAD, PAD, COMP, DONE} state_t;

   // Left rotate; an amount of 0 yields x because a 32-bit shift clears the word.
   function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
      rotl = (x << n) | (x >> (6'd32 - {1'b0, n}));
   endfunction

   function automatic logic [31:0] p0(input logic [31:0] x);
      p0 = x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
   endfunction

   function automatic logic [31:0] p1(input logic [31:0] x);
      p1 = x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
   endfunction

   function automatic logic [31:0] ff(input logic [5:0] j, input logic [31:0] x,
                                      input logic [31:0] y, input logic [31:0] z);
      ff = (j < 6'd16) ? (x ^ y ^ z) : ((x & y) | (x & z) | (y & z));
   endfunction

   function automatic logic [31:0] gg(input logic [5:0] j, input logic [31:0] x,
                                      input logic [31:0] y, input logic [31:0] z);
      gg = (j < 6'd16) ? (x ^ y ^ z) : ((x & y) | (~x & z));
   endfunction

endpackage

// File: rtl/sm3_round.sv
// sm3_round: one combinational SM3 compression round.
//   st_i  working registers A..H packed, A in bits 255:224
//   w_i   W[j]
//   wp_i  W'[j] = W[j] ^ W[j+4]
//   j_i   round index 0..63
//   st_o  updated A..H, same packing
module sm3_round
   import sm3_pkg::*;
(
   input  logic [255:0] st_i,
   input  logic [31:0]  w_i,
   input  logic [31:0]  wp_i,
   input  logic [5:0]   j_i,
   output logic [255:0] st_o
);

   logic [31:0] a, b, c, d, e, f, g, h;
   logic [31:0] tj, a12, ss1, ss2, tt1, tt2;

   assign {a, b, c, d, e, f, g, h} = st_i;

   assign tj  = (j_i < 6'd16) ? T_LO : T_HI;
   assign a12 = rotl(a, 5'd12);
   // T_j is rotated by j mod 32, so rounds 32-63 wrap back to small amounts.
   assign ss1 = rotl(a12 + e + rotl(tj, j_i[4:0]), 5'd7);
   assign ss2 = ss1 ^ a12;
   assign tt1 = ff(j_i, a, b, c) + d + ss2 + wp_i;
   assign tt2 = gg(j_i, e, f, g) + h + ss1 + w_i;

   assign st_o = {tt1, a, rotl(b, 5'd9), c, p0(tt2), e, rotl(f, 5'd19), g};

endmodule

// File: rtl/sm3_stream_core.sv
// sm3_stream_core: streaming SM3 hash engine, 32-bit big-endian word input.
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready / in_data / in_last / in_bytes   word input handshake;
//                in_bytes gives the valid bytes of the final word (0 = 4)
//   hash_valid   one-cycle pulse when hash carries a new digest
//   hash         digest V0..V7, held until the next digest completes
//   busy         high while a message is in flight (LOAD through DONE)
// RPC (1, 2 or 4) rounds are evaluated per clock by chained sm3_round instances.
module sm3_stream_core
   import sm3_pkg::*;
#(
   parameter int RPC = 1
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   input  logic         in_last,
   input  logic [1:0]   in_bytes,
   output logic         hash_valid,
   output logic [255:0] hash,
   output logic         busy
);

   state_t        state_q, state_d;
   logic          rdy_q;
   logic [3:0]    wcnt_q, wcnt_d;
   logic [63:0]   bitcnt_q, bitcnt_d;
   logic [255:0]  v_q, v_d;
   logic [255:0]  hash_q, hash_d;
   logic [255:0]  wrk_q, wrk_d;
   logic [6:0]    rnd_q, rnd_d;
   logic [3:0]    last_slot_q, last_slot_d;
   logic [4:0]    pad_pos_q, pad_pos_d;     // slot receiving the 0x80 byte (16 = next block)
   logic [1:0]    pad_stage_q, pad_stage_d; // 0: no pad yet, 1: second pad block pending, 2: padding complete
   logic          last_seen_q, last_seen_d;
   logic [31:0]   win_q [16];
   logic [31:0]   win_d [16];

   // The message buffer doubles as the expansion window: during COMP it shifts
   // by RPC words per cycle, with ext[16..] holding the freshly expanded words.
   logic [255:0]  chain [RPC+1];
   logic [31:0]   ext   [16+RPC];

   assign chain[0] = wrk_q;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_win
         assign ext[gi] = win_q[gi];
      end
      for (gi = 0; gi < RPC; gi++) begin : g_rnd
         assign ext[16+gi] = p1(ext[gi] ^ ext[gi+7] ^ rotl(ext[gi+13], 5'd15))
                             ^ rotl(ext[gi+3], 5'd7) ^ ext[gi+10];
         sm3_round u_round (
            .st_i (chain[gi]),
            .w_i  (ext[gi]),
            .wp_i (ext[gi] ^ ext[gi+4]),
            .j_i  (rnd_q[5:0] + 6'(gi)),
            .st_o (chain[gi+1])
         );
      end
   endgenerate

   assign in_ready   = rdy_q & ((state_q == IDLE) | (state_q == LOAD));
   assign hash_valid = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign hash       = hash_q;

   logic        xfer;
   logic [3:0]  slot;
   logic [63:0] bits_base, bits_add;
   logic [31:0] last_word;

   assign xfer      = in_valid & in_ready;
   assign slot      = (state_q == IDLE) ? 4'd0 : wcnt_q;
   assign bits_base = (state_q == IDLE) ? 64'd0 : bitcnt_q;
   assign bits_add  = (in_last && in_bytes != 2'd0) ? {59'd0, in_bytes, 3'd0} : 64'd32;

   // Final word with the 0x80 marker already merged after the last valid byte.
   always_comb begin
      last_word = in_data;
      case (in_bytes)
         2'd1:    last_word = {in_data[31:24], 8'h80, 16'h0000};
         2'd2:    last_word = {in_data[31:16], 8'h80, 8'h00};
         2'd3:    last_word = {in_data[31:8], 8'h80};
         default: last_word = in_data;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      bitcnt_d    = bitcnt_q;
      v_d         = v_q;
      hash_d      = hash_q;
      wrk_d       = wrk_q;
      rnd_d       = rnd_q;
      last_slot_d = last_slot_q;
      pad_pos_d   = pad_pos_q;
      pad_stage_d = pad_stage_q;
      last_seen_d = last_seen_q;
      for (int i = 0; i < 16; i++) win_d[i] = win_q[i];

      case (state_q)
         IDLE, LOAD: begin
            if (state_q == IDLE) begin
               v_d         = SM3_IV;
               wcnt_d      = 4'd0;
               bitcnt_d    = 64'd0;
               pad_stage_d = 2'd0;
               last_seen_d = 1'b0;
            end
            if (xfer) begin
               win_d[slot] = in_last ? last_word : in_data;
               bitcnt_d    = bits_base + bits_add;
               wcnt_d      = slot + 4'd1;
               if (in_last) begin
                  last_seen_d = 1'b1;
                  last_slot_d = slot;
                  pad_pos_d   = {1'b0, slot} + ((in_bytes == 2'd0) ? 5'd1 : 5'd0);
                  state_d     = PAD;
               end else if (slot == 4'd15) begin
                  wrk_d   = v_q;
                  rnd_d   = 7'd0;
                  state_d = COMP;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         PAD: begin
            for (int i = 0; i < 16; i++) begin
               if (pad_stage_q == 2'd0) begin
                  if (i > int'(last_slot_q))
                     win_d[i] = (i == int'(pad_pos_q)) ? 32'h8000_0000 : 32'd0;
               end else begin
                  win_d[i] = (i == 0 && pad_pos_q == 5'd16) ? 32'h8000_0000 : 32'd0;
               end
            end
            if (pad_stage_q != 2'd0 || pad_pos_q <= 5'd13) begin
               win_d[14] = bitcnt_q[63:32];
               win_d[15] = bitcnt_q[31:0];
            end
            pad_stage_d = (pad_stage_q == 2'd0 && pad_pos_q >= 5'd14) ? 2'd1 : 2'd2;
            wrk_d       = v_q;
            rnd_d       = 7'd0;
            state_d     = COMP;
         end
         COMP: begin
            if (rnd_q < 7'd64) begin
               wrk_d = chain[RPC];
               for (int i = 0; i < 16; i++) win_d[i] = ext[i+RPC];
               rnd_d = rnd_q + 7'(RPC);
            end else begin
               v_d   = v_q ^ wrk_q;
               rnd_d = 7'd0;
               if (!last_seen_q) begin
                  state_d = LOAD;
               end else if (pad_stage_q == 2'd1) begin
                  state_d = PAD;
               end else begin
                  hash_d  = v_q ^ wrk_q;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rdy_q       <= 1'b0;
         wcnt_q      <= 4'd0;
         bitcnt_q    <= 64'd0;
         v_q         <= SM3_IV;
         hash_q      <= 256'd0;
         wrk_q       <= 256'd0;
         rnd_q       <= 7'd0;
         last_slot_q <= 4'd0;
         pad_pos_q   <= 5'd0;
         pad_stage_q <= 2'd0;
         last_seen_q <= 1'b0;
         for (int i = 0; i < 16; i++) win_q[i] <= 32'd0;
      end else begin
         state_q     <= state_d;
         rdy_q       <= 1'b1;
         wcnt_q      <= wcnt_d;
         bitcnt_q    <= bitcnt_d;
         v_q         <= v_d;
         hash_q      <= hash_d;
         wrk_q       <= wrk_d;
         rnd_q       <= rnd_d;
         last_slot_q <= last_slot_d;
         pad_pos_q   <= pad_pos_d;
         pad_stage_q <= pad_stage_d;
         last_seen_q <= last_seen_d;
         for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
      end
   end

endmodule
